// File: rtl/down_counter_tc.sv
// Loadable down counter with registered terminal-count pulse and zero flag.
// Optional periodic auto-reload mode: define DOWN_COUNTER_AUTO_RELOAD_EN.
module down_counter_tc #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    input  logic             auto,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             zero,
    output logic             busy
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_dec_d;
    logic             tc_q;
    logic             zero_q;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
`endif

    // Decrement that can never wrap below zero.
    function automatic logic [WIDTH-1:0] dec_sat(input logic [WIDTH-1:0] v);
        return (v == '0) ? '0 : v - ONE;
    endfunction

    always_comb begin
        count_dec_d = dec_sat(count_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            tc_q     <= 1'b0;
            zero_q   <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            tc_q <= 1'b0;
            if (load) begin
                // A load always wins over en, so a load on the last count swallows the tc.
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                reload_q <= data;
`endif
                count_q <= data;
                if (data != '0) begin
                    state_q <= RUN;
                    zero_q  <= 1'b0;
                end else begin
                    state_q <= IDLE;
                    zero_q  <= 1'b1;
                end
            end else if (state_q == RUN && en) begin
                if (count_q == ONE) begin
                    tc_q <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                    if (auto) begin
                        count_q <= reload_q;
                    end else begin
                        count_q <= '0;
                        zero_q  <= 1'b1;
                        state_q <= IDLE;
                    end
`else
                    count_q <= '0;
                    zero_q  <= 1'b1;
                    state_q <= IDLE;
`endif
                end else begin
                    count_q <= count_dec_d;
                end
            end
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign zero  = zero_q;
    assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_tc.sv
// Self-checking bench for down_counter_tc: directed test-plan steps, then
// randomized steps checked against an integer "remaining count" model.
module tb_down_counter_tc;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] data;
    logic         en;
    logic [W-1:0] count;
    logic         tc;
    logic         zero;
    logic         busy;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic         auto;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: remaining count; the counter is busy whenever it is nonzero.
    int m_cnt    = 0;
    int m_reload = 0;
    bit m_tc     = 0;
    bit prev_tc  = 0;
    bit auto_v   = 0;

    down_counter_tc #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (data),
        .en    (en),
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        .auto  (auto),
`endif
        .count (count),
        .tc    (tc),
        .zero  (zero),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit l, input int d, input bit e);
        if (r) begin
            m_cnt = 0; m_reload = 0; m_tc = 0;
        end else if (l) begin
            m_cnt = d; m_reload = d; m_tc = 0;
        end else if (e && m_cnt > 0) begin
            if (m_cnt == 1) begin
                m_tc  = 1;
                m_cnt = auto_v ? m_reload : 0;
            end else begin
                m_cnt = m_cnt - 1;
                m_tc  = 0;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    // Drive on the falling edge, let one rising edge occur, compare on the next falling edge.
    task automatic step(input bit r, input bit l, input int d, input bit e);
        rst  = r;
        load = l;
        data = d[W-1:0];
        en   = e;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        auto = auto_v;
`endif
        @(posedge clk);
        model_edge(r, l, d, e);
        @(negedge clk);
        check("count", int'(count), m_cnt);
        check("tc",    int'(tc),    int'(m_tc));
        check("zero",  int'(zero),  int'(m_cnt == 0));
        check("busy",  int'(busy),  int'(m_cnt != 0));
`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
        check("tc_not_consecutive", int'(prev_tc && tc), 0);
`endif
        prev_tc = tc;
    endtask

    initial begin
        int edges;
        int tc_seen;
        rst = 1'b1; load = 1'b0; data = '0; en = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        auto = 1'b0;
`endif
        @(negedge clk);

        // Reset state
        step(1, 0, 0, 0);
        check("reset_count", int'(count), 0);
        check("reset_zero",  int'(zero), 1);

        // Load 3 then count with en held high: 3,2,1,0 with tc at 0
        step(0, 1, 3, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("tc_at_zero",   int'(tc), 1);
        check("busy_at_zero", int'(busy), 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("hold_at_zero", int'(count), 0);

        // Load 5, toggle en; tc after exactly 5 enabled edges (bounded wait)
        step(0, 1, 5, 0);
        edges = 0; tc_seen = 0;
        for (int i = 0; i < 20 && !tc_seen; i++) begin
            step(0, 0, 0, i % 2 == 0);
            if (i % 2 == 0) edges++;
            if (tc) tc_seen = 1;
        end
        check("toggle_tc_seen",  tc_seen, 1);
        check("toggle_tc_edges", edges, 5);

        // Load 4, count to 2, reload 12 with en on the same edge
        step(0, 1, 4, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 12, 1);
        check("reload_wins", int'(count), 12);
        step(0, 0, 0, 1);
        check("resume_from_12", int'(count), 11);

        // Load with count==1 and en: load wins, no tc
        step(0, 1, 1, 0);
        step(0, 1, 7, 1);
        check("load_over_tc", int'(tc), 0);

        // Load 0 with en: idle, never tc
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("load0_idle_tc", int'(tc), 0);

        // Reset mid-count aborts without tc
        step(0, 1, 2, 0);
        step(1, 0, 0, 1);
        check("rst_abort_tc", int'(tc), 0);
        step(0, 0, 0, 1);

        // Maximum start value
        step(0, 1, MAXV, 1);
        for (int i = 0; i < MAXV; i++) step(0, 0, 0, 1);
        check("max_tc", int'(tc), 1);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        // Periodic mode: tc on enabled edges 3, 6, 9
        auto_v = 1;
        step(0, 1, 3, 0);
        for (int i = 1; i <= 9; i++) begin
            step(0, 0, 0, 1);
            check("auto_tc_period", int'(tc), int'(i % 3 == 0));
            check("auto_zero_low",  int'(zero), 0);
        end
        auto_v = 0;
        step(1, 0, 0, 0);
`endif

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
            auto_v = ($urandom_range(0, 3) != 0);
`endif
            step($urandom_range(0, 40) == 0,
                 $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, MAXV)),
                 $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
